// File: rtl/cajero_parametrizado_if.sv
// Signal bundle between the ATM controller and its environment (card reader, keypad, host).
interface cajero_parametrizado_if #(
    parameter int N_DIGITOS     = 4,
    parameter int ANCHO_BALANCE = 64,
    parameter int ANCHO_MONTO   = 32
);
    logic                       tarjeta_recibida;
    logic                       tipo_trans;
    logic                       digito_stb;
    logic [3:0]                 digito;
    logic [4*N_DIGITOS-1:0]     pin;
    logic [ANCHO_BALANCE-1:0]   balance_inicial;
    logic                       monto_stb;
    logic [ANCHO_MONTO-1:0]     monto;
    logic [ANCHO_BALANCE-1:0]   balance_actualizado;
    logic                       balance_stb;
    logic                       entregar_dinero;
    logic                       pin_incorrecto;
    logic                       advertencia;
    logic                       bloqueo;
    logic                       fondos_insuficientes;

    modport master (
        output tarjeta_recibida, tipo_trans, digito_stb, digito, pin, balance_inicial,
               monto_stb, monto,
        input  balance_actualizado, balance_stb, entregar_dinero, pin_incorrecto,
               advertencia, bloqueo, fondos_insuficientes
    );

    modport slave (
        input  tarjeta_recibida, tipo_trans, digito_stb, digito, pin, balance_inicial,
               monto_stb, monto,
        output balance_actualizado, balance_stb, entregar_dinero, pin_incorrecto,
               advertencia, bloqueo, fondos_insuficientes
    );
endinterface

// File: rtl/cajero_parametrizado.sv
// ATM controller: PIN entry with attempt lockout, then one deposit or withdrawal per card.
module cajero_parametrizado #(
    parameter int N_DIGITOS     = 4,
    parameter int ANCHO_BALANCE = 64,
    parameter int ANCHO_MONTO   = 32,
    parameter int MAX_INTENTOS  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    cajero_parametrizado_if.slave bus
);
    localparam int PW  = 4 * N_DIGITOS;
    localparam int CW  = $clog2(N_DIGITOS + 1);
    localparam int BW1 = ANCHO_BALANCE + 1;

    typedef enum logic [2:0] {
        ESPERA, PIN, COMPARAR, MONTO, TRANSACCION, RETIRO_TARJETA, BLOQUEO
    } estado_t;

    function automatic logic [ANCHO_BALANCE-1:0] sumar_saturado(
        input logic [ANCHO_BALANCE-1:0] a,
        input logic [ANCHO_MONTO-1:0]   b
    );
        logic [ANCHO_BALANCE:0] s;
        s = {1'b0, a} + BW1'(b);
        return s[ANCHO_BALANCE] ? {ANCHO_BALANCE{1'b1}} : s[ANCHO_BALANCE-1:0];
    endfunction

    estado_t                  r_estado,      w_estado_sig;
    logic [CW-1:0]            r_dig_cnt,     w_dig_cnt_sig;
    logic [PW-1:0]            r_shift,       w_shift_sig;
    logic [PW-1:0]            r_pin,         w_pin_sig;
    logic [ANCHO_BALANCE-1:0] r_balance,     w_balance_sig;
    logic [ANCHO_MONTO-1:0]   r_monto,       w_monto_sig;
    logic                     r_tipo,        w_tipo_sig;
    logic                     r_fase,        w_fase_sig;
    logic                     r_coincide,    w_coincide_sig;
    logic [3:0]               r_intentos,    w_intentos_sig;
    logic [ANCHO_BALANCE-1:0] r_balance_act, w_balance_act_sig;
    logic                     r_balance_stb, w_balance_stb_sig;
    logic                     r_entregar,    w_entregar_sig;
    logic                     r_pin_inc,     w_pin_inc_sig;
    logic                     r_adv,         w_adv_sig;
    logic                     r_bloqueo,     w_bloqueo_sig;
    logic                     r_fondos,      w_fondos_sig;

    logic [CW-1:0]            w_dig_inc;
    logic [ANCHO_BALANCE-1:0] w_monto_ext;

    assign w_dig_inc   = r_dig_cnt + CW'(1);
    assign w_monto_ext = ANCHO_BALANCE'(r_monto);

    always_comb begin
        w_estado_sig      = r_estado;
        w_dig_cnt_sig     = r_dig_cnt;
        w_shift_sig       = r_shift;
        w_pin_sig         = r_pin;
        w_balance_sig     = r_balance;
        w_monto_sig       = r_monto;
        w_tipo_sig        = r_tipo;
        w_fase_sig        = 1'b0;
        w_coincide_sig    = r_coincide;
        w_intentos_sig    = r_intentos;
        w_balance_act_sig = r_balance_act;
        w_balance_stb_sig = 1'b0;
        w_entregar_sig    = 1'b0;
        w_pin_inc_sig     = 1'b0;
        w_fondos_sig      = 1'b0;

        case (r_estado)
            ESPERA: begin
                if (bus.tarjeta_recibida) begin
                    w_pin_sig     = bus.pin;
                    w_balance_sig = bus.balance_inicial;
                    w_dig_cnt_sig = '0;
                    w_shift_sig   = '0;
                    w_estado_sig  = PIN;
                end
            end
            PIN: begin
                if (!bus.tarjeta_recibida) begin
                    w_estado_sig = ESPERA;
                end else if (bus.digito_stb) begin
                    w_shift_sig   = (r_shift << 4) | PW'(bus.digito);
                    w_dig_cnt_sig = w_dig_inc;
                    if (w_dig_inc == CW'(N_DIGITOS))
                        w_estado_sig = COMPARAR;
                end
            end
            // Two cycles here: the compare is registered first, then acted on,
            // which places pin_incorrecto two edges after the last digit.
            COMPARAR: begin
                if (!bus.tarjeta_recibida) begin
                    w_estado_sig = ESPERA;
                end else if (!r_fase) begin
                    w_coincide_sig = (r_shift == r_pin);
                    w_fase_sig     = 1'b1;
                end else if (r_coincide) begin
                    w_intentos_sig = '0;
                    w_estado_sig   = MONTO;
                end else begin
                    w_intentos_sig = r_intentos + 4'd1;
                    w_pin_inc_sig  = 1'b1;
                    w_dig_cnt_sig  = '0;
                    if (w_intentos_sig == 4'(MAX_INTENTOS))
                        w_estado_sig = BLOQUEO;
                    else
                        w_estado_sig = PIN;
                end
            end
            MONTO: begin
                if (!bus.tarjeta_recibida) begin
                    w_estado_sig = ESPERA;
                end else if (bus.monto_stb) begin
                    w_monto_sig  = bus.monto;
                    w_tipo_sig   = bus.tipo_trans;
                    w_estado_sig = TRANSACCION;
                end
            end
            TRANSACCION: begin
                w_balance_stb_sig = 1'b1;
                if (!r_tipo) begin
                    w_balance_act_sig = sumar_saturado(r_balance, r_monto);
                end else if (w_monto_ext <= r_balance) begin
                    w_balance_act_sig = r_balance - w_monto_ext;
                    w_entregar_sig    = 1'b1;
                end else begin
                    w_balance_act_sig = r_balance;
                    w_fondos_sig      = 1'b1;
                end
                w_balance_sig = w_balance_act_sig;
                w_estado_sig  = RETIRO_TARJETA;
            end
            RETIRO_TARJETA: begin
                if (!bus.tarjeta_recibida)
                    w_estado_sig = ESPERA;
            end
            BLOQUEO: begin
                w_estado_sig = BLOQUEO;
            end
            default: begin
                w_estado_sig = ESPERA;
            end
        endcase

        w_adv_sig     = (w_intentos_sig == 4'(MAX_INTENTOS - 1));
        w_bloqueo_sig = (w_estado_sig == BLOQUEO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado      <= ESPERA;
            r_dig_cnt     <= '0;
            r_shift       <= '0;
            r_pin         <= '0;
            r_balance     <= '0;
            r_monto       <= '0;
            r_tipo        <= 1'b0;
            r_fase        <= 1'b0;
            r_coincide    <= 1'b0;
            r_intentos    <= '0;
            r_balance_act <= '0;
            r_balance_stb <= 1'b0;
            r_entregar    <= 1'b0;
            r_pin_inc     <= 1'b0;
            r_adv         <= 1'b0;
            r_bloqueo     <= 1'b0;
            r_fondos      <= 1'b0;
        end else begin
            r_estado      <= w_estado_sig;
            r_dig_cnt     <= w_dig_cnt_sig;
            r_shift       <= w_shift_sig;
            r_pin         <= w_pin_sig;
            r_balance     <= w_balance_sig;
            r_monto       <= w_monto_sig;
            r_tipo        <= w_tipo_sig;
            r_fase        <= w_fase_sig;
            r_coincide    <= w_coincide_sig;
            r_intentos    <= w_intentos_sig;
            r_balance_act <= w_balance_act_sig;
            r_balance_stb <= w_balance_stb_sig;
            r_entregar    <= w_entregar_sig;
            r_pin_inc     <= w_pin_inc_sig;
            r_adv         <= w_adv_sig;
            r_bloqueo     <= w_bloqueo_sig;
            r_fondos      <= w_fondos_sig;
        end
    end

    assign bus.balance_actualizado  = r_balance_act;
    assign bus.balance_stb          = r_balance_stb;
    assign bus.entregar_dinero      = r_entregar;
    assign bus.pin_incorrecto       = r_pin_inc;
    assign bus.advertencia          = r_adv;
    assign bus.bloqueo              = r_bloqueo;
    assign bus.fondos_insuficientes = r_fondos;
endmodule

// File: tb/tb_cajero_parametrizado.sv
// Randomized bench for cajero_parametrizado: a 64/32-bit and an 8/8-bit instance share stimulus.
module tb_cajero_parametrizado;
    localparam int N   = 4;
    localparam int MAX = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cajero_parametrizado_if #(.N_DIGITOS(N), .ANCHO_BALANCE(64), .ANCHO_MONTO(32)) bus_a ();
    cajero_parametrizado_if #(.N_DIGITOS(N), .ANCHO_BALANCE(8),  .ANCHO_MONTO(8))  bus_b ();

    cajero_parametrizado #(.N_DIGITOS(N), .ANCHO_BALANCE(64), .ANCHO_MONTO(32), .MAX_INTENTOS(MAX))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    cajero_parametrizado #(.N_DIGITOS(N), .ANCHO_BALANCE(8), .ANCHO_MONTO(8), .MAX_INTENTOS(MAX))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    assign bus_b.tarjeta_recibida = bus_a.tarjeta_recibida;
    assign bus_b.tipo_trans       = bus_a.tipo_trans;
    assign bus_b.digito_stb       = bus_a.digito_stb;
    assign bus_b.digito           = bus_a.digito;
    assign bus_b.pin              = bus_a.pin;
    assign bus_b.balance_inicial  = bus_a.balance_inicial[7:0];
    assign bus_b.monto_stb        = bus_a.monto_stb;
    assign bus_b.monto            = bus_a.monto[7:0];

    int checks   = 0;
    int failures = 0;
    int intentos_m = 0;   // reference: consecutive failed attempts since last good PIN / reset

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] obs_ctl();
        return {bus_a.pin_incorrecto, bus_a.balance_stb, bus_a.entregar_dinero,
                bus_a.fondos_insuficientes, bus_a.advertencia, bus_a.bloqueo,
                bus_b.pin_incorrecto, bus_b.balance_stb, bus_b.entregar_dinero,
                bus_b.fondos_insuficientes, bus_b.advertencia, bus_b.bloqueo};
    endfunction

    // Pulse nibbles are {pin_incorrecto, balance_stb, entregar_dinero, fondos_insuficientes}.
    function automatic logic [11:0] exp_ctl(input logic [3:0] pa, input logic [3:0] pb);
        logic adv, bl;
        adv = (intentos_m == MAX - 1);
        bl  = (intentos_m >= MAX);
        return {pa, adv, bl, pb, adv, bl};
    endfunction

    task automatic chk_ctl(input string tag);
        check(tag, 64'(obs_ctl()), 64'(exp_ctl(4'h0, 4'h0)));
    endtask

    // Returns {entregar, fondos, new_balance} for a balance/amount of the given widths.
    function automatic logic [65:0] modelo(input int wb, input int wm, input logic [63:0] bal,
                                           input logic [63:0] m, input logic tipo);
        logic [64:0] lim, b, mm, nb;
        logic ent, fon;
        lim = (65'd1 << wb) - 65'd1;
        b   = {1'b0, bal} & lim;
        mm  = {1'b0, m} & ((65'd1 << wm) - 65'd1);
        ent = 1'b0;
        fon = 1'b0;
        if (!tipo) begin
            nb = b + mm;
            if (nb > lim) nb = lim;
        end else if (mm <= b) begin
            nb  = b - mm;
            ent = 1'b1;
        end else begin
            nb  = b;
            fon = 1'b1;
        end
        return {ent, fon, nb[63:0]};
    endfunction

    function automatic logic [15:0] corromper(input logic [15:0] p);
        int pos;
        logic [3:0] n;
        pos = int'($urandom_range(0, 3));
        n   = 4'($urandom_range(0, 15));
        if (n == p[4*pos +: 4]) n = n ^ 4'h1;
        p[4*pos +: 4] = n;
        return p;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus_a.tarjeta_recibida = 1'($urandom);
        bus_a.digito_stb = 1'($urandom);
        bus_a.monto_stb  = 1'($urandom);
        @(negedge clk);
        intentos_m = 0;
        check("reset_ctl", 64'(obs_ctl()), 64'(exp_ctl(4'h0, 4'h0)));
        check("reset_bal_a", bus_a.balance_actualizado, 64'd0);
        check("reset_bal_b", 64'(bus_b.balance_actualizado), 64'd0);
        reset = 1'b0;
        bus_a.tarjeta_recibida = 1'b0;
        bus_a.digito_stb = 1'b0;
        bus_a.monto_stb  = 1'b0;
    endtask

    task automatic insertar(input logic [15:0] p, input logic [63:0] bal);
        @(negedge clk);
        chk_ctl("idle");
        bus_a.tarjeta_recibida = 1'b1;
        bus_a.pin = p;
        bus_a.balance_inicial = bal;
        @(negedge clk);
        chk_ctl("insert");
        bus_a.pin = 16'($urandom);
        bus_a.balance_inicial = {$urandom, $urandom};
    endtask

    task automatic retirar();
        @(negedge clk);
        chk_ctl("pre_remove");
        bus_a.tarjeta_recibida = 1'b0;
        bus_a.digito_stb = 1'b0;
        bus_a.monto_stb  = 1'b0;
        @(negedge clk);
        chk_ctl("removed");
    endtask

    task automatic digitos(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            chk_ctl("partial_pin");
            bus_a.digito_stb = 1'b1;
            bus_a.digito = 4'($urandom_range(0, 9));
        end
        @(negedge clk);
        chk_ctl("partial_pin");
        bus_a.digito_stb = 1'b0;
    endtask

    task automatic ingresar_pin(input logic [15:0] ent, input logic [15:0] p, output bit ok);
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk_ctl("pin_gap");
                bus_a.digito_stb = 1'b0;
                bus_a.digito = 4'($urandom);
                bus_a.monto_stb = 1'($urandom);
            end
            @(negedge clk);
            chk_ctl("pin_digit");
            bus_a.digito_stb = 1'b1;
            bus_a.digito = ent[4*(N-1-i) +: 4];
            bus_a.monto_stb = 1'($urandom);
        end
        repeat (2) begin
            @(negedge clk);
            chk_ctl("pin_wait");
            bus_a.digito_stb = 1'($urandom);
            bus_a.digito = 4'($urandom);
            bus_a.monto_stb = 1'($urandom);
        end
        @(negedge clk);
        ok = (ent == p);
        if (ok) intentos_m = 0;
        else    intentos_m++;
        check("pin_result", 64'(obs_ctl()),
              64'(exp_ctl(ok ? 4'h0 : 4'h8, ok ? 4'h0 : 4'h8)));
        bus_a.digito_stb = 1'b0;
        bus_a.monto_stb  = 1'b0;
    endtask

    task automatic transaccion(input logic [63:0] bal, input logic tipo, input logic [31:0] m);
        logic [65:0] ra, rb;
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk_ctl("monto_gap");
            bus_a.digito_stb = 1'($urandom);
            bus_a.digito = 4'($urandom);
            bus_a.monto_stb = 1'b0;
        end
        @(negedge clk);
        chk_ctl("monto_strobe");
        bus_a.monto_stb  = 1'b1;
        bus_a.tipo_trans = tipo;
        bus_a.monto      = m;
        bus_a.digito_stb = 1'($urandom);
        ra = modelo(64, 32, bal, 64'(m), tipo);
        rb = modelo(8, 8, bal, 64'(m), tipo);
        @(negedge clk);
        chk_ctl("trans_wait");
        bus_a.monto_stb  = 1'($urandom);
        bus_a.tipo_trans = 1'($urandom);
        bus_a.monto      = $urandom;
        bus_a.digito_stb = 1'($urandom);
        @(negedge clk);
        check("trans_ctl", 64'(obs_ctl()),
              64'(exp_ctl({2'b01, ra[65:64]}, {2'b01, rb[65:64]})));
        check("trans_bal_a", bus_a.balance_actualizado, ra[63:0]);
        check("trans_bal_b", 64'(bus_b.balance_actualizado), rb[63:0]);
        bus_a.monto_stb  = 1'($urandom);
        bus_a.digito_stb = 1'($urandom);
        @(negedge clk);
        chk_ctl("trans_after");
        bus_a.monto_stb  = 1'b0;
        bus_a.digito_stb = 1'b0;
    endtask

    task automatic bloqueado(input int n);
        repeat (n) begin
            @(negedge clk);
            chk_ctl("locked");
            bus_a.tarjeta_recibida = 1'($urandom);
            bus_a.digito_stb = 1'($urandom);
            bus_a.digito = 4'($urandom);
            bus_a.monto_stb = 1'($urandom);
            bus_a.monto = $urandom;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [15:0] p, e;
        logic [63:0] bal;
        logic [31:0] mon;
        logic tp;

        bus_a.tarjeta_recibida = 1'b0;
        bus_a.tipo_trans = 1'b0;
        bus_a.digito_stb = 1'b0;
        bus_a.digito = 4'h0;
        bus_a.pin = 16'h0;
        bus_a.balance_inicial = 64'd0;
        bus_a.monto_stb = 1'b0;
        bus_a.monto = 32'd0;
        do_reset();

        // Correct PIN, withdrawal of 300 from 1000.
        insertar(16'h1234, 64'd1000);
        ingresar_pin(16'h1234, 16'h1234, ok);
        transaccion(64'd1000, 1'b1, 32'd300);
        check("dir_withdraw_bal", bus_a.balance_actualizado, 64'd700);
        retirar();

        // Insufficient funds: 101 from 100.
        insertar(16'h1234, 64'd100);
        ingresar_pin(16'h1234, 16'h1234, ok);
        transaccion(64'd100, 1'b1, 32'd101);
        check("dir_nsf_bal", bus_a.balance_actualizado, 64'd100);
        retirar();

        // Deposit of 10 on 250: saturates at 255 in the 8-bit instance.
        insertar(16'h1234, 64'd250);
        ingresar_pin(16'h1234, 16'h1234, ok);
        transaccion(64'd250, 1'b0, 32'd10);
        check("dir_sat_bal_b", 64'(bus_b.balance_actualizado), 64'd255);
        check("dir_sat_bal_a", bus_a.balance_actualizado, 64'd260);
        retirar();

        // Three bad PINs in one session lock the machine until reset.
        insertar(16'h1234, 64'd500);
        repeat (3) ingresar_pin(16'h1235, 16'h1234, ok);
        check("dir_locked", 64'(bus_a.bloqueo), 64'd1);
        bloqueado(8);
        do_reset();

        // Attempts persist across card removal.
        insertar(16'h1234, 64'd500);
        repeat (2) ingresar_pin(16'h1235, 16'h1234, ok);
        retirar();
        insertar(16'h1234, 64'd500);
        ingresar_pin(16'h1235, 16'h1234, ok);
        bloqueado(4);
        do_reset();

        // Reset in the middle of PIN entry, then a normal session.
        insertar(16'h1234, 64'd42);
        digitos(2);
        do_reset();
        insertar(16'h1234, 64'd42);
        ingresar_pin(16'h1234, 16'h1234, ok);
        transaccion(64'd42, 1'b1, 32'd0);
        retirar();

        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < N; i++) p[4*i +: 4] = 4'($urandom_range(0, 9));
            case ($urandom_range(0, 3))
                0:       bal = {$urandom, $urandom};
                1:       bal = 64'($urandom_range(0, 1000));
                2:       bal = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 100));
                default: bal = 64'($urandom_range(245, 260));
            endcase
            case ($urandom_range(0, 3))
                0:       mon = $urandom;
                1:       mon = 32'($urandom_range(0, 1100));
                2:       mon = 32'd0;
                default: mon = bal[31:0];
            endcase
            tp = 1'($urandom);
            insertar(p, bal);
            if ($urandom_range(0, 9) == 0) begin
                digitos(int'($urandom_range(1, 3)));
                retirar();
                continue;
            end
            ok = 1'b0;
            for (int a = 0; a < MAX; a++) begin
                e = ($urandom_range(0, 1) == 1) ? p : corromper(p);
                ingresar_pin(e, p, ok);
                if (ok || intentos_m >= MAX) break;
                if ($urandom_range(0, 4) == 0) break;
            end
            if (intentos_m >= MAX) begin
                bloqueado(5);
                do_reset();
            end else if (!ok) begin
                retirar();
            end else if ($urandom_range(0, 6) == 0) begin
                retirar();
            end else begin
                transaccion(bal, tp, mon);
                retirar();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
